arrow_hit_judge: RTL and testbench

- Sits between the arrow pattern generator and the score tracker.
- Consumes the generator's `pattern_out`/`pattern_valid` spawn events and both players' key inputs.
- Judges each player's response against the spawned target within a timing window.
- Emits one-cycle `perfect_hit_a`/`perfect_hit_b` pulses (score tracker inputs), plus good/miss pulses and status.
- Two identical, independent per-player judge channels: A uses `pattern_out[7:4]`, B uses `pattern_out[3:0]`.

---
 rtl/arrow_hit_judge.sv | 185 ++++++++++++++++++
 tb/tb_arrow_hit_judge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_hit_judge.sv
// rtl/arrow_hit_judge.sv - two-player arrow response judge (optional combo counter: ARROW_HIT_COMBO_EN)

module arrow_hit_chan #(
  parameter int WINDOW_CYCLES  = 12500000,
  parameter int PERFECT_CYCLES = 5000000,
  parameter int CNT_W          = 25
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       active_i,
  input  logic       spawn_i,
  input  logic [3:0] nibble_i,
  input  logic [3:0] keys_i,
  output logic       perfect_o,
  output logic       good_o,
  output logic       miss_o,
  output logic       armed_o,
  output logic [6:0] combo_o
);

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERF_CNT = CNT_W'(PERFECT_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       target_q, target_d;
  logic             seen_q, seen_d;
  logic             perfect_q, perfect_d;
  logic             good_q, good_d;
  logic             miss_q, miss_d;
  logic [3:0]       sync1_q, keys_s_q, keys_prev_q;
  logic [3:0]       key_edge;
  logic             wrong, match, decided;

  assign key_edge = keys_s_q & ~keys_prev_q;
  assign wrong    = |(key_edge & ~target_q);
  assign match    = (keys_s_q == target_q) && (seen_q || |(key_edge & target_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    seen_d    = seen_q;
    perfect_d = 1'b0;
    good_d    = 1'b0;
    miss_d    = 1'b0;
    decided   = 1'b0;
    if (!active_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      seen_d  = 1'b0;
    end else begin
      if (state_q == S_ARMED) begin
        if (wrong) begin
          miss_d  = 1'b1;
          state_d = S_IDLE;
          decided = 1'b1;
        end else if (match) begin
          if (cnt_q < PERF_CNT) perfect_d = 1'b1;
          else                  good_d    = 1'b1;
          state_d = S_IDLE;
          decided = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          miss_d  = 1'b1;
          state_d = S_IDLE;
          decided = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          seen_d = seen_q | (|(key_edge & target_q));
        end
        // A new spawn retires an unresolved arrow as a miss.
        if (spawn_i && !decided) miss_d = 1'b1;
      end
      if (spawn_i) begin
        if (nibble_i != 4'd0) begin
          state_d  = S_ARMED;
          target_d = nibble_i;
          cnt_d    = '0;
          seen_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      seen_q      <= 1'b0;
      perfect_q   <= 1'b0;
      good_q      <= 1'b0;
      miss_q      <= 1'b0;
      sync1_q     <= '0;
      keys_s_q    <= '0;
      keys_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      seen_q      <= seen_d;
      perfect_q   <= perfect_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      sync1_q     <= keys_i;
      keys_s_q    <= sync1_q;
      keys_prev_q <= keys_s_q;
    end
  end

  assign perfect_o = perfect_q;
  assign good_o    = good_q;
  assign miss_o    = miss_q;
  assign armed_o   = (state_q == S_ARMED);

`ifdef ARROW_HIT_COMBO_EN
  logic [6:0] combo_q, combo_d;

  always_comb begin
    combo_d = combo_q;
    if (active_i) begin
      if (miss_q)                                        combo_d = 7'd0;
      else if ((perfect_q || good_q) && combo_q < 7'd99) combo_d = combo_q + 7'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) combo_q <= 7'd0;
    else         combo_q <= combo_d;
  end

  assign combo_o = combo_q;
`else
  assign combo_o = 7'd0;
`endif

endmodule

module arrow_hit_judge #(
  parameter int WINDOW_CYCLES  = 12500000,
  parameter int PERFECT_CYCLES = 5000000,
  parameter int CNT_W          = 25
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       game_active,
  input  logic [7:0] pattern_out,
  input  logic       pattern_valid,
  input  logic [3:0] player_a_keys,
  input  logic [3:0] player_b_keys,
  output logic       perfect_hit_a,
  output logic       perfect_hit_b,
  output logic       good_hit_a,
  output logic       good_hit_b,
  output logic       miss_a,
  output logic       miss_b,
  output logic       armed_a,
  output logic       armed_b,
  output logic [6:0] combo_a,
  output logic [6:0] combo_b
);

  arrow_hit_chan #(
    .WINDOW_CYCLES(WINDOW_CYCLES), .PERFECT_CYCLES(PERFECT_CYCLES), .CNT_W(CNT_W)
  ) u_chan_a (
    .clk_i(CLOCK_50), .rst_ni(resetn), .active_i(game_active), .spawn_i(pattern_valid),
    .nibble_i(pattern_out[7:4]), .keys_i(player_a_keys),
    .perfect_o(perfect_hit_a), .good_o(good_hit_a), .miss_o(miss_a),
    .armed_o(armed_a), .combo_o(combo_a)
  );

  arrow_hit_chan #(
    .WINDOW_CYCLES(WINDOW_CYCLES), .PERFECT_CYCLES(PERFECT_CYCLES), .CNT_W(CNT_W)
  ) u_chan_b (
    .clk_i(CLOCK_50), .rst_ni(resetn), .active_i(game_active), .spawn_i(pattern_valid),
    .nibble_i(pattern_out[3:0]), .keys_i(player_b_keys),
    .perfect_o(perfect_hit_b), .good_o(good_hit_b), .miss_o(miss_b),
    .armed_o(armed_b), .combo_o(combo_b)
  );

endmodule

// File: tb/tb_arrow_hit_judge.sv
// tb/tb_arrow_hit_judge.sv - scoreboard bench for arrow_hit_judge (combo checks with ARROW_HIT_COMBO_EN)

module tb_arrow_hit_judge;

  localparam int K_PERFECT = 1;
  localparam int K_GOOD    = 2;
  localparam int K_MISS    = 3;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       game_active = 1'b1;
  logic [7:0] pattern_out = 8'h00;
  logic       pattern_valid = 1'b0;
  logic [3:0] player_a_keys = 4'h0;
  logic [3:0] player_b_keys = 4'h0;
  logic       perfect_hit_a, perfect_hit_b, good_hit_a, good_hit_b, miss_a, miss_b;
  logic       armed_a, armed_b;
  logic [6:0] combo_a, combo_b;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  arrow_hit_judge #(.WINDOW_CYCLES(20), .PERFECT_CYCLES(8), .CNT_W(5)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .game_active(game_active),
    .pattern_out(pattern_out), .pattern_valid(pattern_valid),
    .player_a_keys(player_a_keys), .player_b_keys(player_b_keys),
    .perfect_hit_a(perfect_hit_a), .perfect_hit_b(perfect_hit_b),
    .good_hit_a(good_hit_a), .good_hit_b(good_hit_b),
    .miss_a(miss_a), .miss_b(miss_b),
    .armed_a(armed_a), .armed_b(armed_b),
    .combo_a(combo_a), .combo_b(combo_b)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int ch, input int c, input int kind);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    if (ch == 0) qa.push_back(e);
    else         qb.push_back(e);
  endtask

  task automatic mon(input int ch, input logic p, input logic g, input logic m);
    exp_t e;
    int   kind;
    int   sz;
    if (p || g || m) begin
      kind = p ? K_PERFECT : (g ? K_GOOD : K_MISS);
      chk($sformatf("ch%0d_one_pulse", ch), int'(p) + int'(g) + int'(m), 1);
      sz = (ch == 0) ? qa.size() : qb.size();
      if (sz == 0) begin
        chk($sformatf("ch%0d_unexpected_pulse_kind", ch), kind, 0);
      end else begin
        e = (ch == 0) ? qa.pop_front() : qb.pop_front();
        chk($sformatf("ch%0d_pulse_kind", ch), kind, e.kind);
        chk($sformatf("ch%0d_pulse_cycle", ch), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge CLOCK_50) begin
    mon(0, perfect_hit_a, good_hit_a, miss_a);
    mon(1, perfect_hit_b, good_hit_b, miss_b);
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge CLOCK_50);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic strobe(input logic [7:0] pat, output int e0);
    pattern_out   = pat;
    pattern_valid = 1'b1;
    e0            = cyc + 1;
    @(negedge CLOCK_50);
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    idle(3);
    chk("rst_pulses", {perfect_hit_a, perfect_hit_b, good_hit_a, good_hit_b, miss_a, miss_b}, 0);
    chk("rst_armed", {armed_a, armed_b}, 0);
    chk("rst_combo", {combo_a, combo_b}, 0);
    resetn = 1'b1;
    idle(3);

    // 88: A presses UP at +3 -> perfect at cnt 5; B times out at +20
    strobe(8'h88, e0);
    push(0, e0 + 6, K_PERFECT);
    push(1, e0 + 20, K_MISS);
    chk("t1_armed_a", armed_a, 1);
    at_cyc(e0 + 3); player_a_keys = 4'b1000;
    at_cyc(e0 + 21); player_a_keys = 4'h0;
    chk("t1_idle_b", armed_b, 0);
    idle(4);

    // AA: A builds the pair UP then LEFT -> good at cnt 12; B holds only UP -> timeout
    strobe(8'hAA, e0);
    push(0, e0 + 13, K_GOOD);
    push(1, e0 + 20, K_MISS);
    at_cyc(e0 + 1);  player_a_keys = 4'b1000;
    at_cyc(e0 + 2);  player_b_keys = 4'b1000;
    at_cyc(e0 + 10); player_a_keys = 4'b1010;
    at_cyc(e0 + 21); player_a_keys = 4'h0; player_b_keys = 4'h0;
    idle(4);

    // 11: RIGHT held before arming never matches
    player_a_keys = 4'b0001;
    idle(4);
    strobe(8'h11, e0);
    push(0, e0 + 20, K_MISS);
    push(1, e0 + 20, K_MISS);
    at_cyc(e0 + 21);
    idle(4);
    // release at arming, re-press -> perfect at cnt 4
    strobe(8'h11, e0);
    player_a_keys = 4'h0;
    push(0, e0 + 5, K_PERFECT);
    push(1, e0 + 20, K_MISS);
    at_cyc(e0 + 2); player_a_keys = 4'b0001;
    at_cyc(e0 + 21); player_a_keys = 4'h0;
    idle(4);

    // 44: A presses LEFT (wrong); B presses DOWN landing on cnt 8 -> good
    strobe(8'h44, e0);
    push(0, e0 + 5, K_MISS);
    push(1, e0 + 9, K_GOOD);
    at_cyc(e0 + 2); player_a_keys = 4'b0010;
    at_cyc(e0 + 4); chk("t4_armed_before", armed_a, 1);
    @(negedge CLOCK_50); chk("t4_armed_after_wrong", armed_a, 0);
    at_cyc(e0 + 6); player_b_keys = 4'b0100;
    at_cyc(e0 + 10); player_a_keys = 4'h0; player_b_keys = 4'h0;
    chk("t4_armed_b_after_good", armed_b, 0);
    idle(4);

    // AA: A adds RIGHT to the pair -> miss; B exact pair at once -> perfect
    strobe(8'hAA, e0);
    player_a_keys = 4'b1011;
    player_b_keys = 4'b1010;
    push(0, e0 + 3, K_MISS);
    push(1, e0 + 3, K_PERFECT);
    at_cyc(e0 + 4); player_a_keys = 4'h0; player_b_keys = 4'h0;
    idle(4);

    // 22 re-strobed at cnt 10, then game_active drops at cnt 5
    strobe(8'h22, e0);
    at_cyc(e0 + 10);
    push(0, e0 + 11, K_MISS);
    push(1, e0 + 11, K_MISS);
    strobe(8'h22, e1);
    chk("t5_rearm_a", armed_a, 1);
    chk("t5_rearm_b", armed_b, 1);
    at_cyc(e1 + 5); game_active = 1'b0;
    @(negedge CLOCK_50);
    chk("t5_abort_armed", {armed_a, armed_b}, 0);
    strobe(8'h88, e0);
    chk("t5_inactive_strobe", {armed_a, armed_b}, 0);
    idle(25);
    game_active = 1'b1;
    idle(2);

    // 80 arms only A; 08 while A armed retires it as a miss and arms B
    strobe(8'h80, e0);
    chk("t6_armed_a", armed_a, 1);
    chk("t6_zero_nibble_b", armed_b, 0);
    at_cyc(e0 + 4);
    push(0, cyc + 1, K_MISS);
    strobe(8'h08, e1);
    push(1, e1 + 20, K_MISS);
    chk("t6_a_idle", armed_a, 0);
    chk("t6_b_armed", armed_b, 1);
    at_cyc(e1 + 21);
    idle(2);

    // reset mid-window: no pulse, back to idle
    strobe(8'h88, e0);
    at_cyc(e0 + 5);
    resetn = 1'b0;
    #1;
    chk("t7_reset_armed", {armed_a, armed_b}, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    idle(25);

`ifdef ARROW_HIT_COMBO_EN
    for (int i = 0; i < 101; i++) begin
      strobe(8'h80, e0);
      player_a_keys = 4'b1000;
      push(0, e0 + 3, K_PERFECT);
      at_cyc(e0 + 4);
      chk($sformatf("combo_a_%0d", i + 1), combo_a, (i + 1 > 99) ? 99 : i + 1);
      player_a_keys = 4'h0;
      idle(3);
    end
    strobe(8'h80, e0);
    player_a_keys = 4'b0100;
    push(0, e0 + 3, K_MISS);
    at_cyc(e0 + 4);
    chk("combo_a_clear", combo_a, 0);
    chk("combo_b_idle", combo_b, 0);
    player_a_keys = 4'h0;
    idle(4);
`else
    chk("combo_tied_a", combo_a, 0);
    chk("combo_tied_b", combo_b, 0);
`endif

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
